id_ex_pipe: RTL
===============

Name: id_ex_pipe

Overview:
- ID/EX boundary of the 5-stage RISC-V pipeline, directly downstream of the ID control-signal decoder.
- Registers the decoded control bundle, operands, immediate and register indices into EX.
- Detects load-use hazards against the instruction currently in EX. Drives `ban` back to the decoder and a stall to IF/ID.
- Honours EX flush (taken branch/jump) and a downstream memory stall.

Parameters:
- XLEN, 32, datapath width for PC, immediate and operands.
- CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_imm  in  XLEN  extended immediate
- id_rs1_data  in  XLEN  register-file read port 1
- id_rs2_data  in  XLEN  register-file read port 2
- id_rs1  in  5  source index 1
- id_rs2  in  5  source index 2
- id_rd  in  5  destination index
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2
- id_ctrl  in  16  decoder bundle, packed as {Branch[2:0], ALUBSrc[1:0], ALUctr[3:0], MemOp[2:0], RegWr, MemtoReg, ALUASrc, MemWr}, MSB first
- ex_flush  in  1  EX resolved a taken branch/jump; squash ID
- mem_stall  in  1  MEM busy; freeze ID/EX
- ban  out  1  to decoder: force all control outputs to zero
- if_id_stall  out  1  hold PC and the IF/ID register
- ex_valid  out  1  EX slot holds a real instruction
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN each  registered copies of the ID inputs
- ex_rs1, ex_rs2, ex_rd  out  5 each  registered indices
- ex_ctrl  out  16  registered control bundle, same packing as id_ctrl

Behaviour:
- Hazard, combinational from current EX registers and ID inputs:
  - load_use = ex_valid & ex_ctrl.RegWr & ex_ctrl.MemtoReg & (ex_rd != 0) & id_valid & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- Outputs, combinational:
  - ban = load_use | ex_flush.
  - if_id_stall = (load_use | mem_stall) & ~ex_flush.
- Bubble = ex_valid 0 and ex_ctrl 0 (RegWr=0, MemWr=0, Branch=000). Data fields of a bubble are don't-care but must be driven as 0.
- Register update at each posedge; first matching case wins:
  1. rst: all ex_* outputs cleared to 0, ex_valid=0.
  2. ex_flush: load bubble. Flush overrides mem_stall and load_use; the squashed ID instruction is lost.
  3. mem_stall: hold every ex_* register unchanged.
  4. load_use: load bubble. IF/ID is held, so the same ID instruction is re-presented next cycle.
  5. Otherwise: capture all id_* inputs. ex_valid=id_valid. ex_ctrl = id_valid ? id_ctrl : 0.
- Latency: exactly 1 cycle from ID to EX when no hazard or stall.
- Load-use costs exactly one bubble. Cycle after the bubble, ex_valid=0, so load_use deasserts and the instruction advances.
- Load into x0 never triggers load_use.
- ex_flush and load_use in the same cycle: bubble, if_id_stall=0.
- mem_stall with load_use: hold, if_id_stall=1. The hazard is re-evaluated after the stall releases.
- Reset asserted mid-stall: clears immediately on that edge.
- Outputs are combinational in the cycle reset is asserted, evaluated on the post-reset register state.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, adds two output ports:
  - bubble_cnt  out  CNT_W: increments on each edge that loads a load_use bubble.
  - flush_cnt  out  CNT_W: increments on each edge where ex_flush is taken.
- Both counters reset to 0, saturate at all-ones, and do not count during mem_stall hold.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles → every ex_* output 0, ban=0, if_id_stall=0.
- Straight-line flow: addi x5,x0,7 presented at id_pc=0x100 → next cycle ex_pc=0x100, ex_rd=5, ex_ctrl.RegWr=1, ex_valid=1.
- Load-use: lw x6 in EX, then add x7,x6,x1 in ID → ban=1 and if_id_stall=1 for one cycle. Next edge, EX holds a bubble. The cycle after, add is in EX with ex_rs1=6. bubble_cnt=1 when the feature is enabled.
- Load to x0: lw x0 in EX, ID reads rs1=0 → no stall, add advances in 1 cycle.
- Flush priority: ex_flush=1 together with load_use and mem_stall → next ex_valid=0, ex_ctrl=0, if_id_stall=0. flush_cnt increments by 1.
- mem_stall for 3 cycles with sw in EX → ex_* unchanged for 3 edges, if_id_stall=1 throughout. On release, the ID instruction is captured on the next edge.

Source files
------------

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register for the 5-stage RISC-V core.
// Captures the decoded control bundle, operands, immediate and register
// indices into EX. It detects load-use hazards against the EX instruction,
// and it honours EX flush (taken branch/jump) and a downstream MEM stall.
// Optional build macro: ID_EX_PERF_CNT_EN adds saturating bubble/flush counters.
module id_ex_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [15:0]     id_ctrl,
    input  logic            ex_flush,
    input  logic            mem_stall,
    output logic            ban,
    output logic            if_id_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [4:0]      ex_rd,
    output logic [15:0]     ex_ctrl
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    // Bit positions inside the control bundle:
    // {Branch[2:0], ALUBSrc[1:0], ALUctr[3:0], MemOp[2:0], RegWr, MemtoReg, ALUASrc, MemWr}
    localparam int unsigned CTRL_REGWR    = 3;
    localparam int unsigned CTRL_MEMTOREG = 2;

    // Elaboration-time parameter sanity checks.
    if (XLEN < 1) begin : g_bad_xlen
        $error("id_ex_pipe: XLEN must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("id_ex_pipe: CNT_W must be at least 1");
    end

    // What the EX register bank does on the next edge (reset handled separately).
    typedef enum logic [1:0] {
        UPD_FLUSH,
        UPD_HOLD,
        UPD_BUBBLE,
        UPD_CAPTURE
    } upd_e;

    logic ex_is_load;
    logic rs1_hit;
    logic rs2_hit;
    logic load_use;
    upd_e upd;

    // Load-use hazard: EX holds a load into a nonzero register that ID reads.
    always_comb begin
        ex_is_load = ex_valid && ex_ctrl[CTRL_REGWR] && ex_ctrl[CTRL_MEMTOREG];
        rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
        load_use   = ex_is_load && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);
    end

    // Back-pressure to the decoder and the IF/ID register.
    always_comb begin
        ban         = load_use || ex_flush;
        if_id_stall = (load_use || mem_stall) && !ex_flush;
    end

    // Priority selection of the register update: flush > stall hold > bubble > capture.
    always_comb begin
        upd = UPD_CAPTURE;
        if (ex_flush) begin
            upd = UPD_FLUSH;
        end else if (mem_stall) begin
            upd = UPD_HOLD;
        end else if (load_use) begin
            upd = UPD_BUBBLE;
        end
    end

    // ID/EX register bank; bubbles zero every field so nothing downstream acts on them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl     <= '0;
        end else begin
            unique case (upd)
                UPD_FLUSH, UPD_BUBBLE: begin
                    ex_valid    <= 1'b0;
                    ex_pc       <= '0;
                    ex_imm      <= '0;
                    ex_rs1_data <= '0;
                    ex_rs2_data <= '0;
                    ex_rs1      <= '0;
                    ex_rs2      <= '0;
                    ex_rd       <= '0;
                    ex_ctrl     <= '0;
                end
                UPD_HOLD: begin
                    ex_valid    <= ex_valid;
                    ex_pc       <= ex_pc;
                    ex_imm      <= ex_imm;
                    ex_rs1_data <= ex_rs1_data;
                    ex_rs2_data <= ex_rs2_data;
                    ex_rs1      <= ex_rs1;
                    ex_rs2      <= ex_rs2;
                    ex_rd       <= ex_rd;
                    ex_ctrl     <= ex_ctrl;
                end
                UPD_CAPTURE: begin
                    ex_valid    <= id_valid;
                    ex_pc       <= id_pc;
                    ex_imm      <= id_imm;
                    ex_rs1_data <= id_rs1_data;
                    ex_rs2_data <= id_rs2_data;
                    ex_rs1      <= id_rs1;
                    ex_rs2      <= id_rs2;
                    ex_rd       <= id_rd;
                    ex_ctrl     <= id_valid ? id_ctrl : '0;
                end
                default: begin
                    ex_valid <= 1'b0;
                    ex_ctrl  <= '0;
                end
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // Saturating performance counters; a held (mem_stall) edge never counts.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if ((upd == UPD_BUBBLE) && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + 1'b1;
            end
            if ((upd == UPD_FLUSH) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
